// File: rtl/selen_boot_pkg.sv
// Shared types and constants for the SPI flash boot loader.
package selen_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    WB_WR,
    DONE
  } boot_state_t;

  localparam logic [7:0]  SPI_CMD_READ = 8'h03;
  localparam int unsigned SPI_CMD_BITS = 32;

  // Flash bytes arrive first-byte-in-MSB; RAM word is little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: sclk divider, 32-bit shift out/in, bit counter.
// load_i starts a 32-bit transfer (sclk low, first bit already on mosi);
// done_o pulses in the cycle whose edge produces the 32nd falling sclk.
module spi_bit_engine
  import selen_boot_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] tx_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic [31:0] rx_o,
  output logic        done_o
);

  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax  = DivW'(CLK_DIV - 1);
  localparam logic [4:0]      LastBit = 5'(SPI_CMD_BITS - 1);

  logic            active_q, active_d;
  logic            sclk_q, sclk_d;
  logic [DivW-1:0] div_q, div_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [31:0]     tx_q, tx_d;
  logic [31:0]     rx_q, rx_d;
  logic            tick;

  assign tick   = active_q && (div_q == DivMax);
  assign done_o = tick && sclk_q && (cnt_q == LastBit);
  assign sclk_o = sclk_q;
  assign mosi_o = active_q & tx_q[31];
  assign rx_o   = rx_q;

  // Divider, sclk toggle, sample on rise, shift on fall.
  always_comb begin
    active_d = active_q;
    sclk_d   = sclk_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if (load_i) begin
      active_d = 1'b1;
      sclk_d   = 1'b0;
      div_d    = '0;
      cnt_d    = '0;
      tx_d     = tx_i;
    end else if (active_q) begin
      if (tick) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          rx_d = {rx_q[30:0], miso_i};
        end else begin
          tx_d  = {tx_q[30:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LastBit) active_d = 1'b0;
        end
      end else begin
        div_d = div_q + DivW'(1);
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/spi_flash_boot.sv
// SPI flash boot loader: READ command to the flash, stream BOOT_WORDS words,
// write each to RAM over a wishbone master, then raise done_o.
// Optional build macro SPI_BOOT_CHECKSUM_EN: read one extra sum word and flag
// a mismatch against the wrap-around sum of the copied words on err_o.
module spi_flash_boot
  import selen_boot_pkg::*;
#(
  parameter logic [23:0]  FLASH_ADDR = 24'h000000,
  parameter int unsigned  BOOT_WORDS = 1024,
  parameter logic [31:0]  RAM_BASE   = 32'h0000_0000,
  parameter int unsigned  CLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        spi_ss_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i
);

  localparam int unsigned IdxW = $clog2(BOOT_WORDS + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BOOT_WORDS - 1);

  boot_state_t     state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            eng_load;
  logic [31:0]     eng_tx;
  logic [31:0]     eng_rx;
  logic            eng_done;
  logic [31:0]     rd_word;

`ifdef SPI_BOOT_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        sum_phase_q, sum_phase_d;
  logic        err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign rd_word = bswap32(eng_rx);

  spi_bit_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_engine (
    .clk    (clk),
    .rst    (rst),
    .load_i (eng_load),
    .tx_i   (eng_tx),
    .miso_i (spi_miso_i),
    .sclk_o (spi_sclk_o),
    .mosi_o (spi_mosi_o),
    .rx_o   (eng_rx),
    .done_o (eng_done)
  );

  // State, word index and checksum registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
`ifdef SPI_BOOT_CHECKSUM_EN
      sum_q       <= '0;
      sum_phase_q <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
`ifdef SPI_BOOT_CHECKSUM_EN
      sum_q       <= sum_d;
      sum_phase_q <= sum_phase_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next state; each engine load is issued on the transition into CMD/DATA.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    eng_load    = 1'b0;
    eng_tx      = 32'h0;
`ifdef SPI_BOOT_CHECKSUM_EN
    sum_d       = sum_q;
    sum_phase_d = sum_phase_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = CMD;
          idx_d       = '0;
          eng_load    = 1'b1;
          eng_tx      = {SPI_CMD_READ, FLASH_ADDR};
`ifdef SPI_BOOT_CHECKSUM_EN
          sum_d       = '0;
          sum_phase_d = 1'b0;
          err_d       = 1'b0;
`endif
        end
      end
      CMD: begin
        if (eng_done) begin
          state_d  = DATA;
          eng_load = 1'b1;
        end
      end
      DATA: begin
        if (eng_done) begin
`ifdef SPI_BOOT_CHECKSUM_EN
          if (sum_phase_q) begin
            state_d = DONE;
            err_d   = (rd_word != sum_q);
          end else begin
            state_d = WB_WR;
          end
`else
          state_d = WB_WR;
`endif
        end
      end
      WB_WR: begin
        if (wbm_ack_i) begin
`ifdef SPI_BOOT_CHECKSUM_EN
          sum_d = sum_q + rd_word;
`endif
          if (idx_q == LastIdx) begin
`ifdef SPI_BOOT_CHECKSUM_EN
            // Stay in continuous READ for the trailing sum word.
            sum_phase_d = 1'b1;
            state_d     = DATA;
            eng_load    = 1'b1;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d    = idx_q + IdxW'(1);
            state_d  = DATA;
            eng_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'h0;
    wbm_adr_o = 32'h0;
    wbm_dat_o = 32'h0;
    unique case (state_q)
      CMD, DATA: busy_o = 1'b1;
      WB_WR: begin
        busy_o    = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = RAM_BASE + (32'(idx_q) << 2);
        wbm_dat_o = rd_word;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
    spi_ss_o = ~busy_o;
  end

endmodule

// File: tb/tb_spi_flash_boot.sv
// Bench for spi_flash_boot: behavioural READ-capable flash, wishbone RAM with
// programmable ack latency, and a second instance at a non-zero flash address.
module tb_spi_flash_boot;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned BOOT_WORDS = 4;
  localparam int          BUDGET     = 4000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;

  // Instance A: FLASH_ADDR 0.
  logic        busy, done, err, ss, sclk, mosi, miso;
  logic        cyc, stb, we, ack;
  logic [31:0] adr, dat;
  logic [3:0]  sel;

  // Instance B: FLASH_ADDR 0x000100, zero-wait ack, miso low.
  logic        busy2, done2, err2, ss2, sclk2, mosi2;
  logic        cyc2, stb2, we2;
  logic [31:0] adr2, dat2;
  logic [3:0]  sel2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_flash_boot #(
    .FLASH_ADDR (24'h000000),
    .BOOT_WORDS (BOOT_WORDS),
    .RAM_BASE   (32'h0000_0000),
    .CLK_DIV    (CLK_DIV)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .spi_ss_o   (ss),
    .spi_sclk_o (sclk),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat),
    .wbm_sel_o  (sel),
    .wbm_ack_i  (ack)
  );

  spi_flash_boot #(
    .FLASH_ADDR (24'h000100),
    .BOOT_WORDS (BOOT_WORDS),
    .RAM_BASE   (32'h0000_0000),
    .CLK_DIV    (CLK_DIV)
  ) u_dut_ofs (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .busy_o     (busy2),
    .done_o     (done2),
    .err_o      (err2),
    .spi_ss_o   (ss2),
    .spi_sclk_o (sclk2),
    .spi_mosi_o (mosi2),
    .spi_miso_i (1'b0),
    .wbm_cyc_o  (cyc2),
    .wbm_stb_o  (stb2),
    .wbm_we_o   (we2),
    .wbm_adr_o  (adr2),
    .wbm_dat_o  (dat2),
    .wbm_sel_o  (sel2),
    .wbm_ack_i  (stb2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- flash model (N25Q READ, mode 0) ----------------
  logic [7:0]  flash [0:511];
  int          fl_bit = 0;
  logic [31:0] fl_cmd = '0;
  initial miso = 1'b0;

  always @(posedge sclk or posedge ss) begin
    if (ss === 1'b1) begin
      fl_bit = 0;
    end else begin
      if (fl_bit < 32) fl_cmd = {fl_cmd[30:0], mosi};
      fl_bit = fl_bit + 1;
    end
  end

  always @(negedge sclk) begin
    int k;
    logic [7:0] b;
    if (ss === 1'b0 && fl_bit >= 32) begin
      k = fl_bit - 32;
      b = flash[(int'(fl_cmd[23:0]) + k / 8) % 512];
      miso <= b[7 - (k % 8)];
    end
  end

  // Command capture for instance B.
  int          fl2_bit = 0;
  logic [31:0] fl2_cmd = '0;
  always @(posedge sclk2 or posedge ss2) begin
    if (ss2 === 1'b1) begin
      fl2_bit = 0;
    end else begin
      if (fl2_bit < 32) fl2_cmd = {fl2_cmd[30:0], mosi2};
      fl2_bit = fl2_bit + 1;
    end
  end

  // ---------------- wishbone RAM model ----------------
  logic [31:0] ram [0:15];
  int ack_delay = 0;
  int wait_cnt  = 0;
  int wr_count  = 0;
  int wr2_count = 0;
  int wr2_nonzero = 0;

  assign ack = stb && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (stb && !ack) wait_cnt <= wait_cnt + 1;
    else             wait_cnt <= 0;
    if (cyc && stb && ack) begin
      ram[adr[5:2]] <= dat;
      wr_count      <= wr_count + 1;
    end
    if (cyc2 && stb2) begin
      wr2_count <= wr2_count + 1;
      if (dat2 != 32'h0 || sel2 != 4'hF || !we2) wr2_nonzero <= wr2_nonzero + 1;
    end
  end

  // Bus stability and sclk-quiet monitor while a write is pending.
  int          stab_err = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_adr, hold_dat;
  always @(posedge clk) begin
    if (!rst) begin
      hold_v <= 1'b0;
    end else if (stb) begin
      if (sclk) stab_err <= stab_err + 1;
      if (hold_v && (adr !== hold_adr || dat !== hold_dat || sel !== 4'hF || !we || !cyc))
        stab_err <= stab_err + 1;
      hold_v   <= !ack;
      hold_adr <= adr;
      hold_dat <= dat;
    end else begin
      hold_v <= 1'b0;
    end
  end

  // Cycles from the ack cycle to the first sclk-high sample.
  int   min_gap = 1000;
  int   gap_cnt = 0;
  logic gap_armed = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      gap_armed = 1'b0;
    end else if (stb && ack) begin
      gap_armed = 1'b1;
      gap_cnt   = 0;
    end else if (gap_armed) begin
      gap_cnt++;
      if (sclk) begin
        if (gap_cnt < min_gap) min_gap = gap_cnt;
        gap_armed = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (done !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 16; i++) ram[i] = 32'hDEAD_BEEF;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctl"},
             {19'h0, ss, sclk, mosi, cyc, stb, we, sel, busy, done, err},
             32'h0000_1000);
    check_eq({tag, "_adr"}, adr, 32'h0);
    check_eq({tag, "_dat"}, dat, 32'h0);
  endtask

  task automatic check_image(input string tag);
    check_eq({tag, "_ram0"}, ram[0], 32'h0302_0100);
    check_eq({tag, "_ram1"}, ram[1], 32'h0706_0504);
    check_eq({tag, "_ram2"}, ram[2], 32'h0B0A_0908);
    check_eq({tag, "_ram3"}, ram[3], 32'h0F0E_0D0C);
    check_eq({tag, "_wr_count"}, wr_count, 32'd4);
    check_eq({tag, "_done_ss_busy"}, {29'h0, done, ss, busy}, 32'b110);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 512; i++) flash[i] = 8'(i);
`ifdef SPI_BOOT_CHECKSUM_EN
    // Sum of the four image words is 0x24201C18, stored little-endian.
    flash[16] = 8'h18; flash[17] = 8'h1C; flash[18] = 8'h20; flash[19] = 8'h24;
`endif
    clear_ram();

    // Reset state.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    check_eq("reset_b_ss_busy", {30'h0, ss2, busy2}, 32'b10);
    rst = 1'b1;
    @(negedge clk);

    // T1: basic copy, zero-wait ack; instance B runs alongside.
    ack_delay = 0;
    pulse_start();
    check_eq("t1_first_cmd_cycle", {29'h0, busy, ss, mosi}, 32'b100);
    wait_done_a();
    check_image("t1");
    check_eq("t1_err", {31'h0, err}, 32'h0);
    check_eq("t1_cmd_mosi", fl_cmd, 32'h0300_0000);
    check_eq("t1_idle_spi", {30'h0, sclk, mosi}, 32'h0);
    for (int n = 0; n < BUDGET && done2 !== 1'b1; n++) @(negedge clk);
    check_eq("t1b_done_ss", {30'h0, done2, ss2}, 32'b11);
    check_eq("t1b_cmd_mosi", fl2_cmd, 32'h0300_0100);
    check_eq("t1b_wr_count", wr2_count, 32'd4);
    check_eq("t1b_wr_data", wr2_nonzero, 32'd0);
    check_eq("t1b_err", {31'h0, err2}, 32'h0);

    // T2: 5-cycle ack latency, plus a start pulse while busy.
    clear_ram();
    wr_count  = 0;
    stab_err  = 0;
    min_gap   = 1000;
    ack_delay = 5;
    pulse_start();
    repeat (200) @(negedge clk);
    check_eq("t2_busy_before_restart", {31'h0, busy}, 32'h1);
    pulse_start();
    check_eq("t2_busy_after_restart", {31'h0, busy}, 32'h1);
    wait_done_a();
    check_image("t2");
    check_eq("t2_bus_stable", stab_err, 32'd0);
    check_eq("t2_ack_to_sclk_gap_ok", {31'h0, min_gap >= int'(CLK_DIV) + 1}, 32'h1);
    check_eq("t2_err", {31'h0, err}, 32'h0);

    // T3: reset during the second word, then a clean restart.
    clear_ram();
    wr_count  = 0;
    ack_delay = 0;
    pulse_start();
    for (int n = 0; n < BUDGET && wr_count < 1; n++) @(negedge clk);
    repeat (30) @(negedge clk);
    check_eq("t3_busy_mid", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("t3_reset");
    check_eq("t3_wr_count_after_reset", wr_count, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    clear_ram();
    wr_count = 0;
    pulse_start();
    wait_done_a();
    check_image("t3");
    check_eq("t3_cmd_mosi", fl_cmd, 32'h0300_0000);

`ifdef SPI_BOOT_CHECKSUM_EN
    // T4: corrupted sum word flags err_o; the next start clears it.
    flash[16] = 8'h19;
    wr_count = 0;
    pulse_start();
    wait_done_a();
    check_eq("t4_bad_sum_err_done", {30'h0, err, done}, 32'b11);
    check_eq("t4_wr_count", wr_count, 32'd4);
    flash[16] = 8'h18;
    wr_count = 0;
    pulse_start();
    check_eq("t4_err_cleared_on_start", {30'h0, err, done}, 32'b00);
    wait_done_a();
    check_eq("t4_good_sum_err_done", {30'h0, err, done}, 32'b01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
